// File: rtl/tinyodin_obi_slave.sv
// OBI slave front end for the tinyODIN core: decodes single-word OBI accesses onto
// the spike/neuron/synapse memories and the control register, with a one-cycle response.
module tinyodin_obi_slave #(
  parameter int N         = 256,
  parameter int SPK_WORDS = 64,
  parameter int SYN_WORDS = 8192
) (
  input  logic        CLK,
  input  logic        RST,
  // OBI slave port
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  // shared memory bus
  output logic [2:0]  mem_cs_o,
  output logic        mem_we_o,
  output logic [12:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] spk_rdata_i,
  input  logic [31:0] neur_rdata_i,
  input  logic [31:0] syn_rdata_i,
  // core control
  input  logic        core_busy_i,
  output logic        start_o,
  output logic [7:0]  timesteps_o
);

  localparam int SPK_AW  = $clog2(SPK_WORDS);
  localparam int NEUR_AW = $clog2(N);
  localparam int SYN_AW  = $clog2(SYN_WORDS);

  typedef enum logic [1:0] {
    REG_SPK  = 2'b00,
    REG_NEUR = 2'b01,
    REG_SYN  = 2'b10,
    REG_CTRL = 2'b11
  } region_t;

  region_t     region;
  logic        ctrl_read;
  logic        gnt;
  logic [12:0] word_idx;
  logic [2:0]  mem_cs;

  region_t     region_reg;
  logic        pending_reg;
  logic        write_reg;
  logic [31:0] ctrl_rdata_reg;
  logic [7:0]  timesteps_reg;
  logic        start_reg;

  // Byte enables and the undecoded address bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{be_i, addr_i};

  always_comb begin
    region    = region_t'(addr_i[21:20]);
    ctrl_read = (region == REG_CTRL) & ~we_i;
    // While busy only control reads pass; reset masks the grant entirely.
    gnt       = req_i & ~RST & ~(core_busy_i & ~ctrl_read);

    word_idx = '0;
    mem_cs   = '0;
    case (region)
      REG_SPK: begin
        word_idx[SPK_AW-1:0] = addr_i[SPK_AW+1:2];
        mem_cs[0]            = gnt;
      end
      REG_NEUR: begin
        word_idx[NEUR_AW-1:0] = addr_i[NEUR_AW+1:2];
        mem_cs[1]             = gnt;
      end
      REG_SYN: begin
        word_idx[SYN_AW-1:0] = addr_i[SYN_AW+1:2];
        mem_cs[2]            = gnt;
      end
      default: begin
        word_idx = '0;
        mem_cs   = '0;
      end
    endcase
  end

  assign gnt_o       = gnt;
  assign mem_cs_o    = mem_cs;
  assign mem_we_o    = gnt & we_i & (region != REG_CTRL);
  assign mem_addr_o  = word_idx;
  assign mem_wdata_o = wdata_i;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_reg    <= 1'b0;
      region_reg     <= REG_SPK;
      write_reg      <= 1'b0;
      ctrl_rdata_reg <= '0;
      timesteps_reg  <= '0;
      start_reg      <= 1'b0;
    end else begin
      pending_reg    <= gnt;
      region_reg     <= region;
      write_reg      <= we_i;
      ctrl_rdata_reg <= {timesteps_reg, 13'b0, 1'b0, 9'b0, core_busy_i};
      start_reg      <= gnt & (region == REG_CTRL) & we_i & wdata_i[10];
      if (gnt && (region == REG_CTRL) && we_i) begin
        timesteps_reg <= wdata_i[31:24];
      end
    end
  end

  // A reset in the response cycle drops the pending response immediately.
  assign rvalid_o    = pending_reg & ~RST;
  assign start_o     = start_reg & ~RST;
  assign timesteps_o = timesteps_reg;

  always_comb begin
    rdata_o = '0;
    if (rvalid_o && !write_reg) begin
      case (region_reg)
        REG_SPK:  rdata_o = spk_rdata_i;
        REG_NEUR: rdata_o = neur_rdata_i;
        REG_SYN:  rdata_o = syn_rdata_i;
        default:  rdata_o = ctrl_rdata_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyodin_obi_slave.sv
// Bench for tinyodin_obi_slave: table of memory transactions plus hand sequences for
// control, busy stalls and reset; responses checked through an expected-data queue.
module tb_tinyodin_obi_slave;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic [2:0]  mem_cs_o;
  logic        mem_we_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] spk_rdata_i, neur_rdata_i, syn_rdata_i;
  logic        core_busy_i;
  logic        start_o;
  logic [7:0]  timesteps_o;

  tinyodin_obi_slave dut (
    .CLK(CLK), .RST(RST),
    .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .spk_rdata_i(spk_rdata_i), .neur_rdata_i(neur_rdata_i), .syn_rdata_i(syn_rdata_i),
    .core_busy_i(core_busy_i), .start_o(start_o), .timesteps_o(timesteps_o)
  );

  always #5 CLK = ~CLK;

  // Simple memories with one-cycle registered read behind the shared bus.
  logic [31:0] spk_mem [64];
  logic [31:0] neur_mem [256];
  logic [31:0] syn_mem [8192];

  always @(posedge CLK) begin
    if (mem_cs_o[0]) begin
      if (mem_we_o) spk_mem[mem_addr_o[5:0]] <= mem_wdata_o;
      spk_rdata_i <= spk_mem[mem_addr_o[5:0]];
    end
    if (mem_cs_o[1]) begin
      if (mem_we_o) neur_mem[mem_addr_o[7:0]] <= mem_wdata_o;
      neur_rdata_i <= neur_mem[mem_addr_o[7:0]];
    end
    if (mem_cs_o[2]) begin
      if (mem_we_o) syn_mem[mem_addr_o] <= mem_wdata_o;
      syn_rdata_i <= syn_mem[mem_addr_o];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Response monitor: every rvalid must match the oldest expected response.
  always @(negedge CLK) begin
    if (!RST && rvalid_o) begin
      if (sb.size() == 0) check("unexpected_rvalid", rvalid_o, 1'b0);
      else check("rdata", rdata_o, sb.pop_front());
    end
  end

  // Drive one transaction at posedge+1; it must be granted in that same cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] exp_cs, input logic [12:0] exp_maddr,
                       input logic [31:0] exp_rdata, input string name);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    @(negedge CLK);
    check({name, "_gnt"}, gnt_o, 1'b1);
    check({name, "_cs"}, mem_cs_o, exp_cs);
    if (exp_cs != 3'b000) begin
      check({name, "_maddr"}, mem_addr_o, exp_maddr);
      check({name, "_mwe"}, mem_we_o, we);
      if (we) check({name, "_mwdata"}, mem_wdata_o, wdata);
    end
    if (gnt_o) sb.push_back(exp_rdata);
    $display("txn %s we=%0d addr=%h wdata=%h exp_rdata=%h", name, we, addr, wdata, exp_rdata);
    @(posedge CLK); #1;
    req_i = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  exp_cs;
    logic [12:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0010_0014, 32'h0015_E000, 3'b010, 13'd5,    32'h0};
    vecs[1] = '{1'b0, 32'h0010_0014, 32'h0,        3'b010, 13'd5,    32'h0015_E000};
    vecs[2] = '{1'b1, 32'h0020_4878, 32'hA5A5_1234, 3'b100, 13'd4638, 32'h0};
    vecs[3] = '{1'b1, 32'h0020_487C, 32'h5A5A_EDCB, 3'b100, 13'd4639, 32'h0};
    vecs[4] = '{1'b0, 32'h0020_4878, 32'h0,        3'b100, 13'd4638, 32'hA5A5_1234};
    vecs[5] = '{1'b0, 32'h0020_487C, 32'h0,        3'b100, 13'd4639, 32'h5A5A_EDCB};
    vecs[6] = '{1'b1, 32'hFFC0_0104, 32'hCAFE_F00D, 3'b001, 13'd1,    32'h0};
    vecs[7] = '{1'b0, 32'h0000_0004, 32'h0,        3'b001, 13'd1,    32'hCAFE_F00D};

    // Reset with a pending control write request: nothing may be granted.
    RST = 1'b1; be_i = 4'hF; core_busy_i = 1'b0;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0030_0000; wdata_i = 32'h3300_0400;
    repeat (2) @(negedge CLK);
    check("rst_gnt", gnt_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_start", start_o, 1'b0);
    check("rst_timesteps", timesteps_o, 8'h00);
    check("rst_cs", mem_cs_o, 3'b000);
    @(posedge CLK); #1;
    RST = 1'b0; req_i = 1'b0;
    @(posedge CLK); #1;

    // Memory transactions, applied back to back.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_cs, vecs[i].exp_maddr,
            vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end
    @(posedge CLK); #1;

    // Control write with START: one-cycle pulse in T+1.
    issue(1'b1, 32'h0030_0000, 32'hFF00_0400, 3'b000, 13'd0, 32'h0, "ctrl_wr");
    @(negedge CLK);
    check("start_t1", start_o, 1'b1);
    check("timesteps", timesteps_o, 8'hFF);
    @(negedge CLK);
    check("start_t2", start_o, 1'b0);
    @(posedge CLK); #1;
    issue(1'b0, 32'h0030_0000, 32'h0, 3'b000, 13'd0, 32'hFF00_0000, "ctrl_rd");

    // Busy: memory write stalls, control read passes, START write stalls.
    core_busy_i = 1'b1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0004; wdata_i = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("busy_spk_gnt", gnt_o, 1'b0);
      check("busy_spk_cs", mem_cs_o, 3'b000);
      @(posedge CLK); #1;
    end
    issue(1'b0, 32'h0030_0000, 32'h0, 3'b000, 13'd0, 32'hFF00_0001, "busy_ctrl_rd");
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0030_0000; wdata_i = 32'h0700_0400;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("busy_ctrl_wr_gnt", gnt_o, 1'b0);
      check("busy_start", start_o, 1'b0);
      @(posedge CLK); #1;
    end
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0004; wdata_i = 32'hFFFF_FFFF;
    @(negedge CLK);
    check("busy_spk_gnt2", gnt_o, 1'b0);
    @(posedge CLK); #1;
    core_busy_i = 1'b0;
    issue(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 3'b001, 13'd1, 32'h0, "idle_spk_wr");
    issue(1'b1, 32'h0030_0000, 32'h0700_0400, 3'b000, 13'd0, 32'h0, "idle_ctrl_wr");
    @(negedge CLK);
    check("idle_start", start_o, 1'b1);
    check("idle_timesteps", timesteps_o, 8'h07);
    @(posedge CLK); #1;
    issue(1'b0, 32'h0000_0004, 32'h0, 3'b001, 13'd1, 32'hFFFF_FFFF, "spk_rd");
    @(posedge CLK); #1;

    // Reset in the cycle after a granted read: response dropped, write discarded.
    issue(1'b0, 32'h0000_0004, 32'h0, 3'b001, 13'd1, 32'hFFFF_FFFF, "rst_rd");
    RST = 1'b1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0030_0000; wdata_i = 32'h1200_0400;
    @(negedge CLK);
    check("rst_drop_rvalid", rvalid_o, 1'b0);
    check("rst_wr_gnt", gnt_o, 1'b0);
    sb.delete();
    @(posedge CLK); #1;
    RST = 1'b0; req_i = 1'b0;
    @(negedge CLK);
    check("post_rst_timesteps", timesteps_o, 8'h00);
    check("post_rst_start", start_o, 1'b0);
    check("post_rst_rvalid", rvalid_o, 1'b0);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
